// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] AR_LEN        = 8'd7;
    localparam logic [2:0] AR_SIZE       = 3'd3;
    localparam logic [1:0] AR_BURST_WRAP = 2'b10;
    localparam logic [1:0] RESP_OKAY     = 2'b00;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LOAD  = 1'b1;

    // Requester index to one-hot port mask.
    function automatic logic [1:0] onehot2(input logic idx);
        return (idx == REQ_LOAD) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; a tie goes to the index that did not win last.
module rr_arbiter2
    import axi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_valid_c,
    output logic       o_grant_c
);

    logic r_last_grant;

    always_comb begin
        o_valid_c = |i_req;
        o_grant_c = REQ_FETCH;
        case (i_req)
            2'b10:   o_grant_c = REQ_LOAD;
            2'b11:   o_grant_c = ~r_last_grant;
            default: o_grant_c = REQ_FETCH;
        endcase
    end

    // Reset to the load index so fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= REQ_LOAD;
        end else if (i_update && o_valid_c) begin
            r_last_grant <= o_grant_c;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port between fetch (0) and load (1); one 8-beat WRAP burst
// outstanding at a time, beats forwarded to the owner with no internal buffering.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned ID_WIDTH    = 13,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned BURST_BEATS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    output logic [1:0]                 req_ready,
    output logic [1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       rsp_last,
    output logic                       rsp_err,
    input  logic [1:0]                 rsp_ready,
    output logic                       proto_err,
    output logic [ID_WIDTH-1:0]        m_axi_arid,
    output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arlock,
    output logic [3:0]                 m_axi_arcache,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [ID_WIDTH-1:0]        m_axi_rid,
    input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam logic [2:0]            LAST_BEAT = 3'(BURST_BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(7);

    state_t                r_state;
    logic                  r_owner;
    logic [2:0]            r_beat_cnt;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [ID_WIDTH-1:0]   r_arid;
    logic                  r_proto_err;

    logic w_in_idle;
    logic w_in_data;
    logic w_grant_valid;
    logic w_grant;
    logic w_beat;
    logic w_cnt_last;
    logic w_rid_bad;

    assign w_in_idle  = (r_state == IDLE) && !reset;
    assign w_in_data  = (r_state == DATA);
    assign w_beat     = w_in_data && m_axi_rvalid && m_axi_rready;
    assign w_cnt_last = (r_beat_cnt == LAST_BEAT);
    assign w_rid_bad  = (m_axi_rid != ID_WIDTH'(r_owner));

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (req_valid),
        .i_update  (w_in_idle),
        .o_valid_c (w_grant_valid),
        .o_grant_c (w_grant)
    );

    // Grant pulse and the zero-latency R path back to the owner.
    always_comb begin
        req_ready = 2'b00;
        if (w_in_idle && w_grant_valid) begin
            req_ready = onehot2(w_grant);
        end
        m_axi_rready = w_in_data && rsp_ready[r_owner];
        rsp_valid    = 2'b00;
        if (w_in_data) begin
            rsp_valid = onehot2(r_owner) & {2{m_axi_rvalid}};
        end
    end

    assign rsp_data  = m_axi_rdata;
    assign rsp_last  = w_in_data && m_axi_rlast;
    assign rsp_err   = w_in_data && (m_axi_rresp != RESP_OKAY);
    assign proto_err = r_proto_err;

    assign m_axi_arid    = r_arid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = AR_LEN;
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = AR_BURST_WRAP;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= REQ_FETCH;
            r_beat_cnt  <= 3'd0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arid      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner   <= w_grant;
                        r_araddr  <= req_addr[w_grant] & LINE_MASK;
                        r_arid    <= ID_WIDTH'(w_grant);
                        r_arvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid  <= 1'b0;
                        r_beat_cnt <= 3'd0;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    // rlast must coincide with the final counted beat.
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 3'd1;
                        if (w_rid_bad || (w_cnt_last != m_axi_rlast)) begin
                            r_proto_err <= 1'b1;
                        end
                        if (w_cnt_last || m_axi_rlast) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: scenario tasks plus a beat scoreboard.
module tb_axi_read_arbiter;

    typedef struct {
        int          port;
        logic [63:0] data;
        logic        last;
        logic        err;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0][63:0]  req_addr;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [63:0]       rsp_data;
    logic              rsp_last;
    logic              rsp_err;
    logic [1:0]        rsp_ready;
    logic              proto_err;
    logic [12:0]       m_axi_arid;
    logic [63:0]       m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arlock;
    logic [3:0]        m_axi_arcache;
    logic [2:0]        m_axi_arprot;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [12:0]       m_axi_rid;
    logic [63:0]       m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    axi_read_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .rsp_err       (rsp_err),
        .rsp_ready     (rsp_ready),
        .proto_err     (proto_err),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Beats handed to a requester are popped from the scoreboard at the negedge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p] && rsp_ready[p]) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat: port=%0d data=%h, none expected", p, rsp_data);
                    end else begin
                        exp_t e;
                        logic [1:0] oh;
                        e  = exp_q.pop_front();
                        oh = (e.port == 1) ? 2'b10 : 2'b01;
                        if (rsp_valid !== oh || rsp_data !== e.data ||
                            rsp_last !== e.last || rsp_err !== e.err) begin
                            bad++;
                            $display("FAIL beat: got valid=%b data=%h last=%b err=%b want valid=%b data=%h last=%b err=%b",
                                     rsp_valid, rsp_data, rsp_last, rsp_err, oh, e.data, e.last, e.err);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Serve one granted burst as the AXI slave; last_at/err_at are beat indices (-1 = none).
    task automatic serve(input int port, input logic [63:0] exp_addr, input int max_wait,
                         input int last_at, input int err_at, input logic [7:0] bp, input bit drop);
        int         w;
        logic [1:0] oh;
        oh = (port == 1) ? 2'b10 : 2'b01;
        w  = 0;
        #1;
        while (req_ready == 2'b00 && w < max_wait) begin
            step();
            #1;
            w++;
        end
        total++;
        if (req_ready !== oh) begin
            bad++;
            $display("FAIL grant: got req_ready=%b want %b", req_ready, oh);
        end
        step();
        if (drop) req_valid[port] = 1'b0;
        #1;
        total++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== exp_addr || m_axi_arid !== 13'(port) ||
            m_axi_arlen !== 8'd7 || m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b10) begin
            bad++;
            $display("FAIL ar_fields: got v=%b addr=%h id=%0d len=%0d size=%0d burst=%b want v=1 addr=%h id=%0d len=7 size=3 burst=10",
                     m_axi_arvalid, m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, exp_addr, port);
        end
        step();
        total++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== exp_addr) begin
            bad++;
            $display("FAIL ar_hold: got v=%b addr=%h want v=1 addr=%h", m_axi_arvalid, m_axi_araddr, exp_addr);
        end
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'(i + 1) * 64'h11;
            m_axi_rresp  = (i == err_at) ? 2'b10 : 2'b00;
            m_axi_rlast  = (i == last_at);
            m_axi_rid    = 13'(port);
            if (bp[i]) begin
                rsp_ready[port] = 1'b0;
                #1;
                total++;
                if (m_axi_rready !== 1'b0 || rsp_valid !== oh || rsp_data !== m_axi_rdata) begin
                    bad++;
                    $display("FAIL stall: got rready=%b rsp_valid=%b data=%h want rready=0 rsp_valid=%b data=%h",
                             m_axi_rready, rsp_valid, rsp_data, oh, m_axi_rdata);
                end
                step();
                rsp_ready[port] = 1'b1;
            end
            exp_q.push_back('{port, 64'(i + 1) * 64'h11, (i == last_at), (i == err_at)});
            #1;
            total++;
            if (m_axi_rready !== 1'b1) begin
                bad++;
                $display("FAIL rready: beat %0d got %b want 1", i, m_axi_rready);
            end
            step();
            if (i == last_at) break;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        #1;
        total++;
        if (m_axi_rready !== 1'b0 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL idle_after: got rready=%b rsp_valid=%b want 0 00", m_axi_rready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        total++;
        if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || req_ready !== 2'b00 ||
            rsp_valid !== 2'b00 || proto_err !== 1'b0 || m_axi_araddr !== 64'h0 || m_axi_arid !== 13'h0) begin
            bad++;
            $display("FAIL reset_state: arv=%b rr=%b rq=%b rv=%b pe=%b addr=%h id=%0d want all 0",
                     m_axi_arvalid, m_axi_rready, req_ready, rsp_valid, proto_err, m_axi_araddr, m_axi_arid);
        end
        total++;
        if (m_axi_arlen !== 8'd7 || m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b10 ||
            m_axi_arlock !== 1'b0 || m_axi_arcache !== 4'h0 || m_axi_arprot !== 3'h0) begin
            bad++;
            $display("FAIL ar_const: len=%0d size=%0d burst=%b lock=%b cache=%h prot=%h want 7 3 10 0 0 0",
                     m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot);
        end
    endtask

    task automatic test_single_fetch();
        req_addr[0]  = 64'h1000_0004;
        req_valid[0] = 1'b1;
        serve(0, 64'h1000_0000, 2, 7, -1, 8'h00, 1'b1);
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL fetch_proto: got %b want 0", proto_err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_addr[0] = 64'h2000_0013;
        req_addr[1] = 64'h3000_003F;
        req_valid   = 2'b11;
        serve(0, 64'h2000_0010, 0, 7, -1, 8'h00, 1'b0);
        serve(1, 64'h3000_0038, 0, 7, -1, 8'h00, 1'b0);
        serve(0, 64'h2000_0010, 0, 7, -1, 8'h00, 1'b0);
        serve(1, 64'h3000_0038, 0, 7, -1, 8'h00, 1'b1);
        serve(0, 64'h2000_0010, 0, 7, -1, 8'h00, 1'b1);
    endtask

    task automatic test_backpressure();
        req_addr[0]  = 64'h4000_0000;
        req_valid[0] = 1'b1;
        serve(0, 64'h4000_0000, 1, 7, -1, 8'b0001_1100, 1'b1);
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_proto: got %b want 0", proto_err);
        end
    endtask

    task automatic test_err_resp();
        req_addr[1]  = 64'h4400_0027;
        req_valid[1] = 1'b1;
        serve(1, 64'h4400_0020, 1, 7, 1, 8'h00, 1'b1);
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("FAIL err_proto: got %b want 0", proto_err);
        end
    endtask

    task automatic test_proto_fault();
        req_addr[0]  = 64'h4800_0040;
        req_valid[0] = 1'b1;
        serve(0, 64'h4800_0040, 1, 4, -1, 8'h00, 1'b1);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL early_last: proto_err got %b want 1", proto_err);
        end
        req_addr[1]  = 64'h4C00_0000;
        req_valid[1] = 1'b1;
        serve(1, 64'h4C00_0000, 1, 7, -1, 8'h00, 1'b1);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL proto_sticky: got %b want 1", proto_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        req_addr[0]  = 64'h5000_0008;
        req_valid    = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL mid_grant: got %b want 01", req_ready);
        end
        step();
        req_valid     = 2'b00;
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'(i + 1) * 64'h11;
            m_axi_rresp  = 2'b00;
            m_axi_rlast  = 1'b0;
            m_axi_rid    = 13'h0;
            exp_q.push_back('{0, 64'(i + 1) * 64'h11, 1'b0, 1'b0});
            step();
        end
        reset       = 1'b1;
        req_addr[1] = 64'h6000_0000;
        req_valid   = 2'b11;
        step();
        total++;
        if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || rsp_valid !== 2'b00 ||
            proto_err !== 1'b0 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset: arv=%b rr=%b rv=%b pe=%b rq=%b want 0 0 00 0 00",
                     m_axi_arvalid, m_axi_rready, rsp_valid, proto_err, req_ready);
        end
        m_axi_rvalid = 1'b0;
        reset        = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL tie_after_reset: got %b want 01", req_ready);
        end
        serve(0, 64'h5000_0008, 0, 7, -1, 8'h00, 1'b1);
        serve(1, 64'h6000_0000, 0, 7, -1, 8'h00, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 2'b00;
        req_addr      = '0;
        rsp_ready     = 2'b11;
        m_axi_arready = 1'b0;
        m_axi_rid     = '0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;

        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_backpressure();
        test_err_resp();
        test_proto_fault();
        test_reset_mid_burst();

        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d beats never delivered, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
